// File: rtl/char_scroll_display.sv
// Rotating-message driver: a MSG_LEN-character message of 2-bit codes scrolled
// across NUM_DISP active-low 7-segment displays, auto-rotated or manually stepped.
module char_scroll_display #(
    parameter int NUM_DISP = 3,
    parameter int MSG_LEN  = 3,
    parameter int DIV_MAX  = 50000000,
    parameter logic [MSG_LEN*2-1:0] MSG_INIT = 6'b10_01_00,
    localparam int OW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    localparam int DW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic [MSG_LEN*2-1:0]    msg,
    input  logic                    load,
    input  logic                    run,
    input  logic                    dir,
    input  logic                    step,
    output logic [NUM_DISP*7-1:0]   hex,
    output logic [OW-1:0]           offset,
    output logic                    tick
);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_MAX - 1);
    localparam logic [OW-1:0] OFF_LAST = OW'(MSG_LEN - 1);

    logic [MSG_LEN*2-1:0]  msg_reg;
    logic [DW-1:0]         div_cnt;
    logic                  step_q;
    logic                  div_last;
    logic                  step_evt;
    logic                  rot_evt;
    logic [OW-1:0]         offset_next;
    logic [NUM_DISP*7-1:0] hex_next;

    // Segment bit k drives segment a+k; a zero lights the segment.
    function automatic logic [6:0] seg7(input logic [1:0] code);
        case (code)
            2'b00:   seg7 = 7'b0100001;
            2'b01:   seg7 = 7'b0000110;
            2'b10:   seg7 = 7'b1111001;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign div_last = (div_cnt == DIV_LAST);
    assign step_evt = step & ~step_q & ~run;
    assign rot_evt  = (run & div_last) | step_evt;

    always_comb begin
        offset_next = offset;
        if (dir == 1'b0)
            offset_next = (offset == OFF_LAST) ? '0 : offset + 1'b1;
        else
            offset_next = (offset == '0) ? OFF_LAST : offset - 1'b1;
    end

    // Display d (0 = rightmost) shows character (offset + NUM_DISP-1-d) mod MSG_LEN.
    always_comb begin
        hex_next = '1;
        for (int d = 0; d < NUM_DISP; d++) begin
            int idx;
            idx = (int'(offset) + NUM_DISP - 1 - d) % MSG_LEN;
            hex_next[7*d +: 7] = seg7(msg_reg[2*idx +: 2]);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            msg_reg <= MSG_INIT;
            offset  <= '0;
            div_cnt <= '0;
            tick    <= 1'b0;
            step_q  <= 1'b1;
            hex     <= '1;
            for (int d = 0; d < NUM_DISP; d++)
                hex[7*d +: 7] <= seg7(MSG_INIT[2*((NUM_DISP - 1 - d) % MSG_LEN) +: 2]);
        end else begin
            step_q <= step;
            tick   <= run & div_last;
            hex    <= hex_next;
            // A load wins over any coincident rotation event.
            if (load) begin
                msg_reg <= msg;
                offset  <= '0;
                div_cnt <= '0;
            end else begin
                if (!run)
                    div_cnt <= '0;
                else if (div_last)
                    div_cnt <= '0;
                else
                    div_cnt <= div_cnt + 1'b1;
                if (rot_evt)
                    offset <= offset_next;
            end
        end
    end

endmodule

// File: tb/tb_char_scroll_display.sv
// Scoreboard bench for char_scroll_display: a 3/3 instance and a 3-display,
// 5-character instance, both with a 4-cycle divider, checked against a character-level model.
module tb_char_scroll_display;

    typedef struct {
        logic [20:0] hex;
        int          off;
        logic        tick;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        resetn_v [2];
    logic        load_v   [2];
    logic        run_v    [2];
    logic        dir_v    [2];
    logic        step_v   [2];
    logic [9:0]  msg_v    [2];

    logic [20:0] hex_a, hex_b;
    logic [1:0]  off_a;
    logic [2:0]  off_b;
    logic        tick_a, tick_b;

    exp_t q0[$];
    exp_t q1[$];

    int   nchecks = 0;
    int   nfails  = 0;

    int   mchar  [2][5];
    int   moff   [2];
    int   mdiv   [2];
    logic mtick  [2];
    logic mstepq [2];
    logic [20:0] mhex [2];
    logic [9:0]  minit [2];

    always #5 CLOCK_50 = ~CLOCK_50;

    char_scroll_display #(.NUM_DISP(3), .MSG_LEN(3), .DIV_MAX(4), .MSG_INIT(6'b10_01_00)) dut_a (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn_v[0]),
        .msg      (msg_v[0][5:0]),
        .load     (load_v[0]),
        .run      (run_v[0]),
        .dir      (dir_v[0]),
        .step     (step_v[0]),
        .hex      (hex_a),
        .offset   (off_a),
        .tick     (tick_a)
    );

    char_scroll_display #(.NUM_DISP(3), .MSG_LEN(5), .DIV_MAX(4), .MSG_INIT(10'b11_11_10_01_00)) dut_b (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn_v[1]),
        .msg      (msg_v[1]),
        .load     (load_v[1]),
        .run      (run_v[1]),
        .dir      (dir_v[1]),
        .step     (step_v[1]),
        .hex      (hex_b),
        .offset   (off_b),
        .tick     (tick_b)
    );

    // Character glyphs written a..g left to right; glyph position k lands on hex bit k.
    function automatic logic [6:0] segOf(input int c);
        logic [0:6] s;
        logic [6:0] r;
        case (c)
            0:       s = 7'b1000010;
            1:       s = 7'b0110000;
            2:       s = 7'b1001111;
            default: s = 7'b1111111;
        endcase
        for (int k = 0; k < 7; k++)
            r[k] = s[k];
        return r;
    endfunction

    function automatic int msgLen(input int u);
        return (u == 0) ? 3 : 5;
    endfunction

    function automatic logic [20:0] decodeExp(input int u);
        logic [20:0] r;
        int ml;
        ml = msgLen(u);
        for (int d = 0; d < 3; d++)
            r[7*d +: 7] = segOf(mchar[u][(moff[u] + 2 - d) % ml]);
        return r;
    endfunction

    task automatic loadChars(input int u, input logic [9:0] m);
        for (int i = 0; i < msgLen(u); i++)
            mchar[u][i] = int'((m >> (2 * i)) & 10'd3);
    endtask

    task automatic modelUpdate(input int u, input logic rn, input logic ld, input logic [9:0] m,
                               input logic run, input logic dir, input logic step);
        int   ml;
        logic evt;
        exp_t e;
        ml = msgLen(u);
        if (!rn) begin
            loadChars(u, minit[u]);
            moff[u]   = 0;
            mdiv[u]   = 0;
            mtick[u]  = 1'b0;
            mstepq[u] = 1'b1;
            mhex[u]   = decodeExp(u);
        end else begin
            mhex[u]   = decodeExp(u);
            evt       = (run && mdiv[u] == 3) || (step && !mstepq[u] && !run);
            mtick[u]  = run && mdiv[u] == 3;
            mstepq[u] = step;
            if (ld) begin
                loadChars(u, m);
                moff[u] = 0;
                mdiv[u] = 0;
            end else begin
                mdiv[u] = run ? (mdiv[u] + 1) % 4 : 0;
                if (evt)
                    moff[u] = dir ? (moff[u] + ml - 1) % ml : (moff[u] + 1) % ml;
            end
        end
        e.hex  = mhex[u];
        e.off  = moff[u];
        e.tick = mtick[u];
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic applyStimulus(input int u, input logic rn, input logic ld, input logic [9:0] m,
                                 input logic run, input logic dir, input logic step);
        resetn_v[u] = rn;
        load_v[u]   = ld;
        msg_v[u]    = m;
        run_v[u]    = run;
        dir_v[u]    = dir;
        step_v[u]   = step;
        @(posedge CLOCK_50);
        modelUpdate(u, rn, ld, m, run, dir, step);
        #1;
    endtask

    task automatic checkOutput(input int u, input exp_t e);
        logic [20:0] h;
        int          o;
        logic        t;
        h = (u == 0) ? hex_a : hex_b;
        o = (u == 0) ? int'(off_a) : int'(off_b);
        t = (u == 0) ? tick_a : tick_b;
        nchecks += 3;
        if (h !== e.hex) begin
            nfails++;
            $display("[TB] FAIL hex u%0d t=%0t: got %b expected %b", u, $time, h, e.hex);
        end
        if (o != e.off || ((u == 0) ? $isunknown(off_a) : $isunknown(off_b))) begin
            nfails++;
            $display("[TB] FAIL offset u%0d t=%0t: got %0d expected %0d", u, $time, o, e.off);
        end
        if (t !== e.tick) begin
            nfails++;
            $display("[TB] FAIL tick u%0d t=%0t: got %b expected %b", u, $time, t, e.tick);
        end
    endtask

    // Monitor: every queued expectation is compared on the falling edge after it was issued.
    always @(negedge CLOCK_50) begin
        if (q0.size() > 0) checkOutput(0, q0.pop_front());
        if (q1.size() > 0) checkOutput(1, q1.pop_front());
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic r_run, r_dir;
        minit[0] = 10'b00_00_10_01_00;
        minit[1] = 10'b11_11_10_01_00;
        for (int u = 0; u < 2; u++) begin
            resetn_v[u] = 1'b0; load_v[u] = 1'b0; run_v[u] = 1'b0;
            dir_v[u] = 1'b0; step_v[u] = 1'b0; msg_v[u] = '0;
        end
        @(posedge CLOCK_50);
        #1;

        // Reset for two cycles, then free-running left rotation.
        $display("[TB] instance A: reset and auto-rotation");
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (14) applyStimulus(0, 1, 0, 0, 1, 0, 0);

        // Manual right step, held step, and step high through reset.
        $display("[TB] instance A: manual stepping");
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 0);
        repeat (5) applyStimulus(0, 1, 0, 0, 0, 1, 1);
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 1, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 1, 1);
        repeat (4) applyStimulus(0, 1, 0, 0, 0, 1, 1);

        // Step toggling while running is ignored; only ticks advance.
        $display("[TB] instance A: step ignored while running");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1, 0, 0, 1, 0, logic'(i % 2 == 0));

        // Reset in the middle of a divider period.
        applyStimulus(0, 1, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 1, 0, 0);

        $display("[TB] instance A: randomized traffic");
        r_run = 1'b1; r_dir = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) r_run = ~r_run;
            if ($urandom_range(0, 7) == 0) r_dir = ~r_dir;
            applyStimulus(0, logic'($urandom_range(0, 39) != 0), logic'($urandom_range(0, 15) == 0),
                          10'($urandom), r_run, r_dir, logic'($urandom_range(0, 1)));
        end

        // Longer message: load coinciding with the divider's last count, then scroll and wrap.
        $display("[TB] instance B: load on tick and scrolling");
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(1, 1, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 1, 10'b11_11_10_01_00, 1, 0, 0);
        repeat (24) applyStimulus(1, 1, 0, 0, 1, 0, 0);
        repeat (12) applyStimulus(1, 1, 0, 0, 1, 1, 0);

        $display("[TB] instance B: randomized traffic");
        r_run = 1'b0; r_dir = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) r_run = ~r_run;
            if ($urandom_range(0, 7) == 0) r_dir = ~r_dir;
            applyStimulus(1, logic'($urandom_range(0, 39) != 0), logic'($urandom_range(0, 15) == 0),
                          10'($urandom), r_run, r_dir, logic'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge CLOCK_50);
        nchecks++;
        if (q0.size() + q1.size() != 0) begin
            nfails++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", q0.size() + q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
        $finish;
    end

endmodule
